multi_cycle_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the single-issue CPU core. A five-phase FSM (IF, ID, EXE, MEM, WB) walks each instruction through its phases and generates every datapath write-enable and mux select. This includes the PC write enable and the 2-bit PC source select feeding the next-PC logic. It sits between the instruction register opcode field, the ALU zero flag and data memory, and drives the register file, ALU muxes, data memory and PC register.

---
 rtl/multi_cycle_sequencer.sv | 159 +++++++++++++++
 tb/tb_multi_cycle_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_sequencer.sv
// Five-phase (IF/ID/EXE/MEM/WB) control FSM; outputs are combinational from phase and opcode, 2-5 cycles per instruction.
// Only MEM can stall (on mem_ready); every other phase advances on each edge, and HALT holds until reset.
module multi_cycle_sequencer (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] state,
  output logic       PCWre,
  output logic [1:0] PCSrc,
  output logic       IRWre,
  output logic       RegWre,
  output logic       RegDst,
  output logic       ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       ExtSel,
  output logic       mRD,
  output logic       mWR,
  output logic       DBDataSrc,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b111
  } state_t;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_BNE  = 6'b110101;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  state_t cur_state, nxt_state;
  logic   illegal_q;

  logic is_rtype, is_addi, is_ori, is_lw, is_sw, is_beq, is_bne, is_j, is_halt, is_legal;

  assign is_rtype = (op == OP_ADD) || (op == OP_SUB) || (op == OP_OR) ||
                    (op == OP_AND) || (op == OP_SLT);
  assign is_addi  = (op == OP_ADDI);
  assign is_ori   = (op == OP_ORI);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_beq   = (op == OP_BEQ);
  assign is_bne   = (op == OP_BNE);
  assign is_j     = (op == OP_J);
  assign is_halt  = (op == OP_HALT);
  assign is_legal = is_rtype | is_addi | is_ori | is_lw | is_sw |
                    is_beq | is_bne | is_j | is_halt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cur_state <= S_IF;
      illegal_q <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      if (cur_state == S_ID && !is_legal) illegal_q <= 1'b1;
    end
  end

  // Raw strobes before reset gating
  logic pc_we, ir_we, rf_we, rd_en, wr_en;

  always_comb begin
    nxt_state = cur_state;
    pc_we     = 1'b0;
    PCSrc     = 2'b00;
    ir_we     = 1'b0;
    rf_we     = 1'b0;
    RegDst    = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = 3'b000;
    ExtSel    = 1'b0;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    DBDataSrc = 1'b0;
    case (cur_state)
      S_IF: begin
        ir_we     = 1'b1;
        nxt_state = S_ID;
      end
      S_ID: begin
        if (is_j) begin
          pc_we     = 1'b1;
          PCSrc     = 2'b10;
          nxt_state = S_IF;
        end else if (is_halt || !is_legal) begin
          nxt_state = S_HALT;
        end else begin
          nxt_state = S_EXE;
        end
      end
      S_EXE: begin
        ALUSrcB = is_addi | is_ori | is_lw | is_sw;
        ExtSel  = is_addi | is_lw | is_sw | is_beq | is_bne;
        case (op)
          OP_SUB, OP_BEQ, OP_BNE: ALUOp = 3'b001;
          OP_OR,  OP_ORI:         ALUOp = 3'b010;
          OP_AND:                 ALUOp = 3'b011;
          OP_SLT:                 ALUOp = 3'b100;
          default:                ALUOp = 3'b000;
        endcase
        if (is_beq || is_bne) begin
          pc_we     = 1'b1;
          PCSrc     = ((is_beq && zero) || (is_bne && !zero)) ? 2'b01 : 2'b00;
          nxt_state = S_IF;
        end else if (is_lw || is_sw) begin
          nxt_state = S_MEM;
        end else begin
          nxt_state = S_WB;
        end
      end
      S_MEM: begin
        rd_en = is_lw;
        wr_en = is_sw;
        if (mem_ready) begin
          if (is_lw) begin
            nxt_state = S_WB;
          end else begin
            pc_we     = 1'b1;
            nxt_state = S_IF;
          end
        end
      end
      S_WB: begin
        rf_we     = 1'b1;
        pc_we     = 1'b1;
        RegDst    = is_rtype;
        DBDataSrc = is_lw;
        nxt_state = S_IF;
      end
      default: nxt_state = S_HALT;
    endcase
  end

  // Strobes drop the instant reset asserts, without waiting for an edge
  assign PCWre   = pc_we & RST;
  assign IRWre   = ir_we & RST;
  assign RegWre  = rf_we & RST;
  assign mRD     = rd_en & RST;
  assign mWR     = wr_en & RST;
  assign state   = cur_state;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_multi_cycle_sequencer.sv
// Directed per-cycle vectors for the sequencer; expected outputs queued by the driver and checked at negedge by a monitor.
module tb_multi_cycle_sequencer;

  logic       CLK, RST, zero, mem_ready;
  logic [5:0] op;
  logic [2:0] state;
  logic       PCWre, IRWre, RegWre, RegDst, ALUSrcB, ExtSel, mRD, mWR, DBDataSrc, illegal;
  logic [1:0] PCSrc;
  logic [2:0] ALUOp;

  multi_cycle_sequencer dut (
    .CLK(CLK), .RST(RST), .op(op), .zero(zero), .mem_ready(mem_ready),
    .state(state), .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .RegWre(RegWre),
    .RegDst(RegDst), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtSel(ExtSel),
    .mRD(mRD), .mWR(mWR), .DBDataSrc(DBDataSrc), .illegal(illegal)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       pcw;
    logic [1:0] pcs;
    logic       irw;
    logic       rgw;
    logic       rdst;
    logic       asb;
    logic [2:0] aop;
    logic       ext;
    logic       mrd;
    logic       mwr;
    logic       dbs;
    logic       ill;
  } vec_t;

  typedef struct {
    vec_t  v;
    string tag;
  } item_t;

  item_t sbq[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  localparam logic [2:0] SIF = 3'b000, SID = 3'b001, SEXE = 3'b010,
                         SMEM = 3'b011, SWB = 3'b100, SHALT = 3'b111;
  localparam logic [5:0] OP_ADD = 6'b000000, OP_ORI = 6'b010010, OP_SLT = 6'b100110,
                         OP_SW = 6'b110000, OP_LW = 6'b110001, OP_BEQ = 6'b110100,
                         OP_BNE = 6'b110101, OP_J = 6'b111000, OP_HALT = 6'b111111,
                         OP_BAD = 6'b101010;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Field order: st, pcw, pcs, irw, rgw, rdst, asb, aop, ext, mrd, mwr, dbs, ill
  function automatic vec_t mk(input logic [2:0] st, input logic pcw, input logic [1:0] pcs,
                              input logic irw, input logic rgw, input logic rdst, input logic asb,
                              input logic [2:0] aop, input logic ext, input logic mrd,
                              input logic mwr, input logic dbs, input logic ill);
    vec_t v;
    v = {st, pcw, pcs, irw, rgw, rdst, asb, aop, ext, mrd, mwr, dbs, ill};
    return v;
  endfunction

  task automatic cyc(input logic r, input logic [5:0] o, input logic z, input logic m,
                     input vec_t e, input string tag);
    item_t it;
    @(posedge CLK);
    #1;
    RST = r; op = o; zero = z; mem_ready = m;
    it.v = e;
    it.tag = tag;
    sbq.push_back(it);
  endtask

  // Monitor: one expected vector per cycle, compared at the falling edge
  initial begin
    item_t it;
    vec_t  got;
    forever begin
      @(negedge CLK);
      if (sbq.size() > 0) begin
        it  = sbq.pop_front();
        got = {state, PCWre, PCSrc, IRWre, RegWre, RegDst, ALUSrcB, ALUOp,
               ExtSel, mRD, mWR, DBDataSrc, illegal};
        n_cmp++;
        if (got !== it.v) begin
          n_bad++;
          $display("FAIL %s: got %b required %b (st,pcw,pcs,irw,rgw,rdst,asb,aop,ext,mrd,mwr,dbs,ill)",
                   it.tag, got, it.v);
        end
      end
    end
  end

  vec_t V_RST, V_IF, V_ID, V_IDJ, V_HALT, V_HALTI;
  vec_t V_ADD_EXE, V_RT_WB, V_SLT_EXE, V_ORI_EXE, V_I_WB;
  vec_t V_BR_TAKEN, V_BR_NOT, V_MEM_EXE, V_LW_MEM, V_LW_WB, V_SW_MEM, V_SW_MEMR;

  initial begin
    RST = 1'b0; op = OP_BAD; zero = 1'b0; mem_ready = 1'b0;

    V_RST      = mk(SIF,   0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    V_IF       = mk(SIF,   0, 2'b00, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    V_ID       = mk(SID,   0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    V_IDJ      = mk(SID,   1, 2'b10, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    V_HALT     = mk(SHALT, 0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    V_HALTI    = mk(SHALT, 0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1);
    V_ADD_EXE  = mk(SEXE,  0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    V_SLT_EXE  = mk(SEXE,  0, 2'b00, 0, 0, 0, 0, 3'b100, 0, 0, 0, 0, 0);
    V_RT_WB    = mk(SWB,   1, 2'b00, 0, 1, 1, 0, 3'b000, 0, 0, 0, 0, 0);
    V_ORI_EXE  = mk(SEXE,  0, 2'b00, 0, 0, 0, 1, 3'b010, 0, 0, 0, 0, 0);
    V_I_WB     = mk(SWB,   1, 2'b00, 0, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    V_BR_TAKEN = mk(SEXE,  1, 2'b01, 0, 0, 0, 0, 3'b001, 1, 0, 0, 0, 0);
    V_BR_NOT   = mk(SEXE,  1, 2'b00, 0, 0, 0, 0, 3'b001, 1, 0, 0, 0, 0);
    V_MEM_EXE  = mk(SEXE,  0, 2'b00, 0, 0, 0, 1, 3'b000, 1, 0, 0, 0, 0);
    V_LW_MEM   = mk(SMEM,  0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 1, 0, 0, 0);
    V_LW_WB    = mk(SWB,   1, 2'b00, 0, 1, 0, 0, 3'b000, 0, 0, 0, 1, 0);
    V_SW_MEM   = mk(SMEM,  0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 1, 0, 0);
    V_SW_MEMR  = mk(SMEM,  1, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 1, 0, 0);

    // Reset held; IF state but all strobes forced low
    cyc(0, OP_BAD, 1, 1, V_RST, "reset0");
    cyc(0, OP_BAD, 0, 1, V_RST, "reset1");

    // add: IF ID EXE WB; garbage op/zero/mem_ready in IF must be ignored
    cyc(1, OP_BAD, 1, 1, V_IF,      "add.IF");
    cyc(1, OP_ADD, 1, 1, V_ID,      "add.ID");
    cyc(1, OP_ADD, 1, 0, V_ADD_EXE, "add.EXE");
    cyc(1, OP_ADD, 0, 0, V_RT_WB,   "add.WB");

    // beq/bne, zero=1 and zero=0
    cyc(1, OP_BAD, 0, 0, V_IF,       "beq1.IF");
    cyc(1, OP_BEQ, 0, 0, V_ID,       "beq1.ID");
    cyc(1, OP_BEQ, 1, 0, V_BR_TAKEN, "beq1.EXE");
    cyc(1, OP_BAD, 1, 0, V_IF,       "beq0.IF");
    cyc(1, OP_BEQ, 1, 0, V_ID,       "beq0.ID");
    cyc(1, OP_BEQ, 0, 0, V_BR_NOT,   "beq0.EXE");
    cyc(1, OP_BAD, 0, 0, V_IF,       "bne1.IF");
    cyc(1, OP_BNE, 0, 0, V_ID,       "bne1.ID");
    cyc(1, OP_BNE, 1, 0, V_BR_NOT,   "bne1.EXE");
    cyc(1, OP_BAD, 1, 0, V_IF,       "bne0.IF");
    cyc(1, OP_BNE, 1, 0, V_ID,       "bne0.ID");
    cyc(1, OP_BNE, 0, 0, V_BR_TAKEN, "bne0.EXE");

    // ori: zero-extended immediate, RegDst=0
    cyc(1, OP_BAD, 0, 0, V_IF,      "ori.IF");
    cyc(1, OP_ORI, 0, 0, V_ID,      "ori.ID");
    cyc(1, OP_ORI, 1, 0, V_ORI_EXE, "ori.EXE");
    cyc(1, OP_ORI, 0, 0, V_I_WB,    "ori.WB");

    // slt
    cyc(1, OP_BAD, 0, 0, V_IF,      "slt.IF");
    cyc(1, OP_SLT, 0, 0, V_ID,      "slt.ID");
    cyc(1, OP_SLT, 0, 0, V_SLT_EXE, "slt.EXE");
    cyc(1, OP_SLT, 0, 0, V_RT_WB,   "slt.WB");

    // lw with three wait cycles: 8 cycles total
    cyc(1, OP_BAD, 0, 1, V_IF,      "lw.IF");
    cyc(1, OP_LW,  0, 1, V_ID,      "lw.ID");
    cyc(1, OP_LW,  0, 0, V_MEM_EXE, "lw.EXE");
    cyc(1, OP_LW,  0, 0, V_LW_MEM,  "lw.MEMw0");
    cyc(1, OP_LW,  0, 0, V_LW_MEM,  "lw.MEMw1");
    cyc(1, OP_LW,  0, 0, V_LW_MEM,  "lw.MEMw2");
    cyc(1, OP_LW,  0, 1, V_LW_MEM,  "lw.MEMrdy");
    cyc(1, OP_LW,  0, 0, V_LW_WB,   "lw.WB");

    // sw zero-wait: mem_ready high already in EXE must not matter
    cyc(1, OP_BAD, 0, 0, V_IF,      "sw.IF");
    cyc(1, OP_SW,  0, 1, V_ID,      "sw.ID");
    cyc(1, OP_SW,  0, 1, V_MEM_EXE, "sw.EXE");
    cyc(1, OP_SW,  0, 1, V_SW_MEMR, "sw.MEMrdy");

    // j
    cyc(1, OP_BAD, 0, 0, V_IF,  "j.IF");
    cyc(1, OP_J,   0, 0, V_IDJ, "j.ID");

    // halt: absorbing, no PCWre for 20 cycles
    cyc(1, OP_BAD,  0, 0, V_IF, "halt.IF");
    cyc(1, OP_HALT, 0, 0, V_ID, "halt.ID");
    for (int i = 0; i < 20; i++)
      cyc(1, (i % 2 == 0) ? OP_ADD : OP_J, i[0], 1, V_HALT, "halt.HALT");
    cyc(0, OP_BAD, 0, 0, V_RST, "halt.rst");

    // undefined opcode: HALT with sticky illegal
    cyc(1, OP_BAD, 0, 0, V_IF,    "ill.IF");
    cyc(1, OP_BAD, 0, 0, V_ID,    "ill.ID");
    cyc(1, OP_ADD, 0, 0, V_HALTI, "ill.HALT0");
    cyc(1, OP_J,   0, 1, V_HALTI, "ill.HALT1");
    cyc(1, OP_ADD, 1, 0, V_HALTI, "ill.HALT2");
    cyc(0, OP_ADD, 0, 0, V_RST,   "ill.rst");

    // Reset in the middle of a stalled sw: no edge between drop and sample
    cyc(1, OP_BAD, 0, 0, V_IF,      "swr.IF");
    cyc(1, OP_SW,  0, 0, V_ID,      "swr.ID");
    cyc(1, OP_SW,  0, 0, V_MEM_EXE, "swr.EXE");
    cyc(1, OP_SW,  0, 0, V_SW_MEM,  "swr.MEMw0");
    cyc(1, OP_SW,  0, 0, V_SW_MEM,  "swr.MEMw1");
    cyc(0, OP_SW,  0, 0, V_RST,     "swr.rst");
    cyc(1, OP_BAD, 0, 0, V_IF,      "swr.relIF");
    cyc(1, OP_J,   0, 0, V_IDJ,     "swr.j.ID");
    cyc(1, OP_BAD, 0, 0, V_IF,      "swr.nextIF");

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge CLK);
    #1;
    if (sbq.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
